// File: rtl/or_gate_if.sv
// Signal bundle for the or_gate cell: operands and controls in, combinational,
// registered and sticky observation outputs back.
interface or_gate_if #(
    parameter int WIDTH = 1
);
    // There is no ready signal. The cell accepts a/b on every rising edge.
    // in_valid only decides whether that sample updates y_q, any_q and sticky.
    // out_valid is in_valid delayed by one cycle and is informational only.
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic             sticky_clr;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;
    logic             any_q;
    logic [WIDTH-1:0] sticky;

    modport master (
        output a, b, in_valid, sticky_clr,
        input  y, y_q, out_valid, any_q, sticky
    );

    modport slave (
        input  a, b, in_valid, sticky_clr,
        output y, y_q, out_valid, any_q, sticky
    );
endinterface

// File: rtl/or_gate.sv
// Bitwise two-input OR with a zero-latency result, a one-cycle registered copy,
// a qualified any-bit flag and a sticky OR accumulator.
module or_gate #(
    parameter int WIDTH = 1
) (
    input logic     clk,
    input logic     rst,
    or_gate_if.slave io
);
    logic [WIDTH-1:0] or_ab;
    logic [WIDTH-1:0] y_q_r;
    logic [WIDTH-1:0] sticky_r;
    logic             out_valid_r;
    logic             any_q_r;

    // The combinational path never touches clk or rst.
    assign or_ab = io.a | io.b;
    assign io.y  = or_ab;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_r       <= '0;
            out_valid_r <= 1'b0;
            any_q_r     <= 1'b0;
            sticky_r    <= '0;
        end else begin
            out_valid_r <= io.in_valid;
            any_q_r     <= io.in_valid & (|or_ab);
            if (io.in_valid) begin
                y_q_r <= or_ab;
            end
            // A clear restarts the accumulator with the current valid sample.
            if (io.sticky_clr) begin
                sticky_r <= io.in_valid ? or_ab : '0;
            end else if (io.in_valid) begin
                sticky_r <= sticky_r | or_ab;
            end
        end
    end

    assign io.y_q       = y_q_r;
    assign io.out_valid = out_valid_r;
    assign io.any_q     = any_q_r;
    assign io.sticky    = sticky_r;
endmodule

// File: tb/tb_or_gate.sv
// Bench for or_gate: WIDTH=1 truth table plus directed and random WIDTH=4
// sequences checked against a sample-history reference model.
module tb_or_gate;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    or_gate_if #(.WIDTH(1)) bus1 ();
    or_gate_if #(.WIDTH(4)) bus4 ();

    or_gate #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .io(bus1));
    or_gate #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .io(bus4));

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: valid samples since the last clear/reset, last valid sample.
    logic [3:0] m_hist[$];
    logic [3:0] m_yq;
    logic       m_ov;
    logic       m_any;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] sticky_ref();
        logic [3:0] s;
        s = 4'b0000;
        foreach (m_hist[i]) s = s | m_hist[i];
        return s;
    endfunction

    // Apply one sample around a rising edge, advance the model, compare everything.
    task automatic step4(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic v, input logic c, input logic r);
        @(negedge clk);
        bus4.a          = a;
        bus4.b          = b;
        bus4.in_valid   = v;
        bus4.sticky_clr = c;
        rst             = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_hist.delete();
            m_yq  = 4'b0000;
            m_ov  = 1'b0;
            m_any = 1'b0;
        end else begin
            m_ov  = v;
            m_any = v && ((a | b) != 4'b0000);
            if (v) m_yq = a | b;
            if (c) m_hist.delete();
            if (v) m_hist.push_back(a | b);
        end
        check({tag, ".y"},         32'(bus4.y),         32'(a | b));
        check({tag, ".y_q"},       32'(bus4.y_q),       32'(m_yq));
        check({tag, ".out_valid"}, 32'(bus4.out_valid), 32'(m_ov));
        check({tag, ".any_q"},     32'(bus4.any_q),     32'(m_any));
        check({tag, ".sticky"},    32'(bus4.sticky),    32'(sticky_ref()));
    endtask

    initial begin
        logic [3:0] ta, tb;
        logic       tv, tc, tr;
        rst             = 1'b0;
        bus1.a          = 1'b0;
        bus1.b          = 1'b0;
        bus1.in_valid   = 1'b0;
        bus1.sticky_clr = 1'b0;
        bus4.a          = 4'b0000;
        bus4.b          = 4'b0000;
        bus4.in_valid   = 1'b0;
        bus4.sticky_clr = 1'b0;
        m_yq            = 4'b0000;
        m_ov            = 1'b0;
        m_any           = 1'b0;

        // WIDTH=1 truth table on the combinational path.
        for (int i = 0; i < 4; i++) begin
            bus1.a = 1'(i >> 1);
            bus1.b = 1'(i);
            #1;
            check($sformatf("tt1.a%0d_b%0d", i >> 1, i & 1), 32'(bus1.y), 32'((i != 0) ? 1 : 0));
        end
        bus1.a = 1'b0;
        bus1.b = 1'b0;

        // Reset held for two edges with everything asserted.
        step4("rst0", 4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
        step4("rst1", 4'hF, 4'hF, 1'b1, 1'b0, 1'b1);
        check("rst.w1.y_q",    32'(bus1.y_q),    32'(0));
        check("rst.w1.sticky", 32'(bus1.sticky), 32'(0));

        // Registered latency and hold.
        step4("lat.valid", 4'b0101, 4'b0010, 1'b1, 1'b0, 1'b0);
        check("lat.y_q_lit", 32'(bus4.y_q), 32'(4'b0111));
        step4("lat.idle", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("lat.hold_lit", 32'(bus4.y_q), 32'(4'b0111));

        // Sticky accumulation.
        step4("stk.rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
        step4("stk.s1", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        check("stk.s1_lit", 32'(bus4.sticky), 32'(4'b0001));
        step4("stk.s2", 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0);
        check("stk.s2_lit", 32'(bus4.sticky), 32'(4'b0101));
        step4("stk.inv", 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("stk.inv_lit", 32'(bus4.sticky), 32'(4'b0101));

        // Simultaneous clear and capture, then plain clear.
        step4("clr.cap", 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0);
        check("clr.cap_lit", 32'(bus4.sticky), 32'(4'b0010));
        step4("clr.only", 4'b0110, 4'b0000, 1'b0, 1'b1, 1'b0);
        check("clr.only_lit", 32'(bus4.sticky), 32'(4'b0000));

        // Reset beats a valid sample.
        step4("pri.load", 4'b1010, 4'b0001, 1'b1, 1'b0, 1'b0);
        step4("pri.rst", 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1);
        check("pri.sticky_lit", 32'(bus4.sticky), 32'(4'b0000));
        check("pri.y_q_lit",    32'(bus4.y_q),    32'(4'b0000));

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            ta = 4'($urandom_range(0, 15));
            tb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) tb = 4'b0000;
            if ($urandom_range(0, 3) == 0) ta = 4'b0000;
            tv = ($urandom_range(0, 3) != 0);
            tc = ($urandom_range(0, 7) == 0);
            tr = ($urandom_range(0, 31) == 0);
            step4($sformatf("rnd%0d", i), ta, tb, tv, tc, tr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
